// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel UART receiver, LSB first.
//
// The asynchronous RX line is brought into the clock domain through a
// two-flop synchroniser. The start bit is qualified half a bit after it is
// first seen. Data bits and the stop bit are then sampled at bit centres.
// A good byte is presented with a one-cycle valid strobe. A low stop bit
// raises a one-cycle framing-error strobe and discards the byte; the FSM
// then waits for the line to return high, so a held-low (break) line is not
// re-read as a start bit.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (legal range 4..65535)
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst_n         synchronous active-low reset
//   i_rx          asynchronous serial input, idles high
//   o_active      high from start detect until the stop-bit sample
//   o_data_valid  one-cycle pulse when a good byte is captured
//   o_data_byte   last good byte, held between frames
//   o_frame_err   one-cycle pulse when the stop bit is sampled low
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_active,
  output logic       o_data_valid,
  output logic [7:0] o_data_byte,
  output logic       o_frame_err
);

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_e;

  // Synchroniser; both flops reset high so reset never looks like a start bit.
  logic rx_meta_q;
  logic rx_s_q;

  state_e      state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        active_q, active_d;
  logic        valid_q,  valid_d;
  logic        ferr_q,   ferr_d;
  logic [7:0]  byte_q,   byte_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      byte_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      byte_q   <= byte_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    active_d = active_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    byte_d   = byte_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) begin
          state_d  = START;
          active_d = 1'b1;
        end
      end

      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
          end else begin
            // Line went high before mid-bit: treat as a glitch.
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
          end else begin
            idx_d   = '0;
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      STOP: begin
        // Leaving at the stop-bit centre gives half a bit of slack for a
        // back-to-back start bit.
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (rx_s_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      BREAK_WAIT: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_active     = active_q;
  assign o_data_valid = valid_q;
  assign o_data_byte  = byte_q;
  assign o_frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver with CLKS_PER_BIT=16.
// The line is driven by an ideal 16-cycle-per-bit model; a negedge monitor
// logs strobes and o_active transitions by clock-edge number.
module tb_uart_receiver;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       i_rx;
  logic       o_active;
  logic       o_data_valid;
  logic [7:0] o_data_byte;
  logic       o_frame_err;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (i_rx),
    .o_active     (o_active),
    .o_data_valid (o_data_valid),
    .o_data_byte  (o_data_byte),
    .o_frame_err  (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc holds the number of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int         vcyc[$];
  logic [7:0] vbyte[$];
  int         fe_cnt   = 0;
  int         fe_cyc   = 0;
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  logic       prev_act = 1'b0;
  logic       both     = 1'b0;

  always @(negedge clk) begin
    if (o_data_valid) begin
      vcyc.push_back(cyc);
      vbyte.push_back(o_data_byte);
    end
    if (o_frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (o_data_valid && o_frame_err) both = 1'b1;
    if (o_active && !prev_act) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (!o_active && prev_act) fall_cyc = cyc;
    prev_act = o_active;
  end

  task automatic clear_mon();
    vcyc.delete();
    vbyte.delete();
    fe_cnt   = 0;
    rise_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    i_rx = v;
    repeat (n) tick();
  endtask

  // t0 is the first edge that samples the start bit low.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc + 1;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop, CPB);
  endtask

  int t0;
  int t1;

  initial begin
    rst_n = 1'b0;
    i_rx  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_active", o_active, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_ferr", o_frame_err, 0);
    check("rst_byte", o_data_byte, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) tick();

    // Single frame 0xA5
    clear_mon();
    send_frame(8'hA5, 1'b1, t0);
    repeat (20) tick();
    check("a5_nvalid", vcyc.size(), 1);
    check("a5_byte", (vbyte.size() > 0) ? vbyte[0] : 8'hxx, 8'hA5);
    check("a5_vtime", (vcyc.size() > 0) ? vcyc[0] - t0 : -1, 154);
    check("a5_ferr", fe_cnt, 0);
    check("a5_rise", rise_cyc - t0, 2);
    check("a5_fall", fall_cyc - t0, 154);
    check("a5_hold", o_data_byte, 8'hA5);

    // Start glitch: 4 cycles low
    clear_mon();
    t0 = cyc + 1;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    check("gl_rises", rise_cnt, 1);
    check("gl_fall", fall_cyc - t0, 10);
    check("gl_active", o_active, 0);
    check("gl_nvalid", vcyc.size(), 0);
    check("gl_ferr", fe_cnt, 0);

    // Framing error then break held low for 50 cycles
    clear_mon();
    send_frame(8'h3C, 1'b0, t0);
    drive_bit(1'b0, 50);
    check("fe_cnt", fe_cnt, 1);
    check("fe_time", fe_cyc - t0, 154);
    check("fe_nvalid", vcyc.size(), 0);
    check("fe_byte", o_data_byte, 8'hA5);
    check("fe_rises", rise_cnt, 1);
    check("fe_active", o_active, 0);
    drive_bit(1'b1, 20);
    check("fe_rises_hi", rise_cnt, 1);
    clear_mon();
    send_frame(8'h00, 1'b1, t0);
    repeat (20) tick();
    check("fe_nx_nvalid", vcyc.size(), 1);
    check("fe_nx_byte", o_data_byte, 8'h00);
    check("fe_nx_ferr", fe_cnt, 0);

    // Back-to-back 0xFF then 0x01, no idle gap
    clear_mon();
    send_frame(8'hFF, 1'b1, t0);
    send_frame(8'h01, 1'b1, t1);
    repeat (20) tick();
    check("b2b_nvalid", vcyc.size(), 2);
    check("b2b_byte0", (vbyte.size() > 0) ? vbyte[0] : 8'hxx, 8'hFF);
    check("b2b_byte1", (vbyte.size() > 1) ? vbyte[1] : 8'hxx, 8'h01);
    check("b2b_gap", (vcyc.size() > 1) ? vcyc[1] - vcyc[0] : -1, 160);
    check("b2b_ferr", fe_cnt, 0);

    // Reset during data bit 4 of 0x5A
    clear_mon();
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(((8'h5A >> i) & 8'h01) != 0, CPB);
    drive_bit(1'b1, 8);
    check("mr_active_pre", o_active, 1);
    rst_n = 1'b0;
    i_rx  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mr_active", o_active, 0);
    check("mr_valid", o_data_valid, 0);
    check("mr_ferr", o_frame_err, 0);
    check("mr_byte", o_data_byte, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) tick();
    check("mr_nvalid", vcyc.size(), 0);
    check("mr_nferr", fe_cnt, 0);
    check("mr_idle", o_active, 0);
    clear_mon();
    send_frame(8'hC3, 1'b1, t0);
    repeat (20) tick();
    check("mr_c3_nvalid", vcyc.size(), 1);
    check("mr_c3_byte", o_data_byte, 8'hC3);
    check("mr_c3_time", (vcyc.size() > 0) ? vcyc[0] - t0 : -1, 154);

    check("excl", both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver (8N1, LSB first) that pairs with the team's UART transmitter on the far end of the link. It synchronises the asynchronous `i_rx` line, detects and qualifies the start bit at mid-bit, samples eight data bits and the stop bit at bit centres, and presents each good byte with a one-cycle valid strobe. Bad stop bits raise a framing-error strobe and discard the byte. The block sits between the board RX pin and the byte-consuming logic.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per UART bit. Legal range is 4..65535. HALF = (CLKS_PER_BIT-1)/2, using integer division.
- `clk`  input  1  system clock; all logic is on its rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `i_rx`  input  1  asynchronous serial line; it idles high.
- `o_active`  output  1  high while a frame is being received, from start detect to the stop sample.
- `o_data_valid`  output  1  one-cycle pulse when a good byte is captured.
- `o_data_byte`  output  8  last good byte; holds its value between frames.
- `o_frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- **Synchroniser:** `i_rx` passes through two flops to give `rx_s`. The FSM uses only `rx_s`.
- **Counters:** bit counter is 16 bits; bit index is 3 bits; the shift register is 8 bits.
- **States:** IDLE, START, DATA, STOP, BREAK_WAIT.

FSM behaviour by state:
- **IDLE:**
  - counter and index are held at 0.
  - If `rx_s`==0: go to START and set `o_active`=1.
- **START:** counter increments each cycle. When counter==HALF:
  - If `rx_s`==0: counter=0, go to DATA.
  - Otherwise it is a glitch: go to IDLE and set `o_active`=0. No strobe is raised.
- **DATA:** counter increments. When counter==CLKS_PER_BIT-1:
  - Set counter=0 and `shift[index]`=`rx_s`.
  - If index<7, index increments.
  - Otherwise index=0 and go to STOP.
- **STOP:** counter increments. When counter==CLKS_PER_BIT-1, set `o_active`=0, then:
  - If `rx_s`==1: `o_data_byte`=shift, `o_data_valid`=1, go to IDLE.
  - If `rx_s`==0: `o_frame_err`=1, `o_data_byte` is unchanged, go to BREAK_WAIT.
- **BREAK_WAIT:** stay until `rx_s`==1, then go to IDLE. This stops a held-low line (break) from being re-read as a start bit.
- `o_data_valid` and `o_frame_err` are each cleared on every cycle other than their set cycle. They are never high together.

Reset, applied at any edge with `rst_n`=0 and including mid-frame:
- Both synchroniser flops = 1.
- state = IDLE.
- counter = 0, index = 0, shift = 0x00.
- `o_active` = 0, `o_data_valid` = 0, `o_frame_err` = 0, `o_data_byte` = 0x00.
- A frame in progress is dropped with no strobe.
- After release, a line that is still low counts as a new start bit.

## Timing
- Let t0 be the first rising edge at which `i_rx` is sampled low.
  - State becomes START and `o_active` rises after edge t0+2.
  - The start bit is qualified at edge t0+3+HALF.
  - Data bit k (k=0..7) is sampled at edge t0+3+HALF+CLKS_PER_BIT·(k+1).
  - The stop bit is sampled at edge t0+3+HALF+9·CLKS_PER_BIT.
  - The strobe and `o_data_byte` update are visible in the cycle after that edge. At the same edge `o_active` falls and the FSM is back in IDLE or BREAK_WAIT.
- The FSM returns to IDLE about half a bit before the stop bit ends, so back-to-back frames with no idle gap are received without loss.
- With CLKS_PER_BIT=16: HALF=7, and the stop sample falls at edge t0+154.

## Test plan
All scenarios use CLKS_PER_BIT=16, with the line driven by an ideal 16-cycle-per-bit model.
- **Single frame:** send 0xA5. Required: `o_data_valid` is a single pulse after edge t0+154, `o_data_byte`=0xA5, `o_frame_err` stays 0, and `o_active` is high from t0+2 to t0+154.
- **Start glitch:** drive `i_rx` low for 4 cycles, then high. Required: `o_active` pulses briefly, returns to 0 after the HALF check, and neither strobe fires.
- **Framing error / break:** after 0xA5 has been received, send 0x3C with the stop bit low and hold the line low for 50 more cycles. Required:
  - one `o_frame_err` pulse, and `o_data_byte` still 0xA5;
  - no new `o_active` until the line has gone high;
  - a following 0x00 frame gives `o_data_valid` with byte 0x00.
- **Back-to-back:** send 0xFF immediately followed by 0x01, with no idle gap. Required: two valid pulses 160 cycles apart, with bytes 0xFF then 0x01.
- **Reset mid-frame:** assert `rst_n`=0 for 3 cycles during data bit 4 of 0x5A, with the line then held idle. Required:
  - all outputs are at reset values on the edge after `rst_n` is sampled low;
  - no strobe fires;
  - a following 0xC3 frame is received correctly.
